// File: rtl/tc_clk.sv
// Technology clock cells: behavioural stand-ins for the library clock
// inverter, OR gate, 2:1 mux and latch-based integrated clock gate.

module tc_clk_inverter (
    input  logic clk_i,
    output logic clk_o
);
    assign clk_o = ~clk_i;
endmodule

module tc_clk_or2 (
    input  logic clk0_i,
    input  logic clk1_i,
    output logic clk_o
);
    assign clk_o = clk0_i | clk1_i;
endmodule

module tc_clk_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);
    assign clk_o = clk_sel_i ? clk1_i : clk0_i;
endmodule

module tc_clk_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);
    logic en_latch_r;

    // Enable latch is transparent only while the clock is low, so the gate opens/closes glitch free
    always_latch begin
        if (!clk_i) begin
            en_latch_r <= en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_latch_r;
endmodule

// File: rtl/clk_div_glitch_free.sv
// Glitch-free programmable clock divider. Divisor changes are handshaked:
// the running period drains, the output gate closes, the new divisor is
// loaded with the counter cleared, and the gate reopens. Divisors 0/1 pass
// the source clock straight through the output gate.

module clk_div_glitch_free #(
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 test_mode_en_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 clk_o
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    localparam logic [DIV_WIDTH-1:0] ZERO         = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] ONE          = DIV_WIDTH'(32'd1);
    localparam logic [DIV_WIDTH-1:0] RESET_DIV    = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic                 RESET_BYPASS = (DEFAULT_DIV < 32'd2) ? 1'b1 : 1'b0;

    // Divisors 0 and 1 select the undivided source clock
    function automatic logic is_bypass_div(input logic [DIV_WIDTH-1:0] div);
        return (div <= ONE);
    endfunction

    state_e               state_r;
    logic [DIV_WIDTH-1:0] div_r;
    logic [DIV_WIDTH-1:0] div_new_r;
    logic [DIV_WIDTH-1:0] cnt_r;
    logic                 gate_en_r;
    logic                 bypass_r;
    logic                 ready_r;
    logic                 pos_phase_r;
    logic                 neg_phase_r;

    logic                 transfer_s;
    logic                 boundary_s;
    logic                 clk_n_s;
    logic                 div_clk_s;
    logic                 bypass_sel_s;
    logic                 sel_clk_s;
    logic                 gated_clk_s;

    assign transfer_s  = div_valid_i & ready_r;
    assign div_ready_o = ready_r;

    // Period boundary: last count of a divide period; trivially reached in bypass or while gated
    always_comb begin
        if (bypass_r || !gate_en_r) begin
            boundary_s = 1'b1;
        end else begin
            boundary_s = (cnt_r == (div_r - ONE));
        end
    end

    // Handshake / drain / load sequencing and the output gate enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_RUN;
            div_r     <= RESET_DIV;
            div_new_r <= RESET_DIV;
            gate_en_r <= 1'b0;
            bypass_r  <= RESET_BYPASS;
            ready_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (transfer_s) begin
                        div_new_r <= div_i;
                        ready_r   <= 1'b0;
                        if (gate_en_r) begin
                            state_r   <= ST_DRAIN;
                            gate_en_r <= en_i | ~boundary_s;
                        end else begin
                            state_r   <= ST_LOAD;
                            gate_en_r <= 1'b0;
                        end
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= ST_RUN;
                        if (gate_en_r) begin
                            gate_en_r <= en_i | ~boundary_s;
                        end else begin
                            gate_en_r <= en_i;
                        end
                    end
                end
                ST_DRAIN: begin
                    ready_r <= 1'b0;
                    if (boundary_s) begin
                        gate_en_r <= 1'b0;
                        state_r   <= ST_LOAD;
                    end else begin
                        gate_en_r <= gate_en_r;
                        state_r   <= ST_DRAIN;
                    end
                end
                ST_LOAD: begin
                    div_r     <= div_new_r;
                    bypass_r  <= is_bypass_div(div_new_r);
                    gate_en_r <= en_i;
                    ready_r   <= 1'b1;
                    state_r   <= ST_RUN;
                end
                default: begin
                    gate_en_r <= 1'b0;
                    ready_r   <= 1'b0;
                    state_r   <= ST_RUN;
                end
            endcase
        end
    end

    // Period counter and rising-edge half: high for floor(N/2) cycles starting at count 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r       <= ZERO;
            pos_phase_r <= 1'b0;
        end else if (state_r == ST_LOAD) begin
            cnt_r       <= ZERO;
            pos_phase_r <= 1'b0;
        end else if (gate_en_r && !bypass_r) begin
            pos_phase_r <= (cnt_r < (div_r >> 1));
            cnt_r       <= boundary_s ? ZERO : (cnt_r + ONE);
        end else begin
            cnt_r       <= cnt_r;
            pos_phase_r <= 1'b0;
        end
    end

    // Half-cycle retimed copy stretches the high phase by 0.5 cycle for odd divisors
    always_ff @(posedge clk_n_s or negedge rst_ni) begin
        if (!rst_ni) begin
            neg_phase_r <= 1'b0;
        end else begin
            neg_phase_r <= pos_phase_r & div_r[0];
        end
    end

    // Reset steers the bypass mux onto the (cleared) divided path so clk_o drops at once
    assign bypass_sel_s = bypass_r & rst_ni;

    tc_clk_inverter i_clk_inv (
        .clk_i (clk_i),
        .clk_o (clk_n_s)
    );

    tc_clk_or2 i_div_or (
        .clk0_i (pos_phase_r),
        .clk1_i (neg_phase_r),
        .clk_o  (div_clk_s)
    );

    tc_clk_mux2 i_bypass_mux (
        .clk0_i    (div_clk_s),
        .clk1_i    (clk_i),
        .clk_sel_i (bypass_sel_s),
        .clk_o     (sel_clk_s)
    );

    tc_clk_gating i_out_gate (
        .clk_i     (sel_clk_s),
        .en_i      (gate_en_r),
        .test_en_i (1'b0),
        .clk_o     (gated_clk_s)
    );

    tc_clk_mux2 i_test_mux (
        .clk0_i    (gated_clk_s),
        .clk1_i    (clk_i),
        .clk_sel_i (test_mode_en_i),
        .clk_o     (clk_o)
    );

endmodule

// File: tb/tb_clk_div_glitch_free.sv
// Directed bench for clk_div_glitch_free (DEFAULT_DIV = 4). clk_o is sampled
// 1 ns after each clk_i edge, giving two half-cycle samples per source cycle;
// expected half-cycle patterns are written out by hand, MSB first.

module tb_clk_div_glitch_free;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       test_mode_en_i;
    logic       en_i;
    logic [7:0] div_i;
    logic       div_valid_i;
    logic       div_ready_o;
    logic       clk_o;

    int vectors     = 0;
    int miscompares = 0;

    clk_div_glitch_free #(
        .DIV_WIDTH   (8),
        .DEFAULT_DIV (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .test_mode_en_i (test_mode_en_i),
        .en_i           (en_i),
        .div_i          (div_i),
        .div_valid_i    (div_valid_i),
        .div_ready_o    (div_ready_o),
        .clk_o          (clk_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // n source cycles; cpat holds 2 bits per cycle (first half, second half), rpat 1 ready bit per cycle
    task automatic run_pat(input string tag, input int n, input logic [63:0] cpat, input logic [31:0] rpat);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            check($sformatf("%s[%0d].hi", tag, i), clk_o, cpat[2*(n-1-i)+1]);
            check($sformatf("%s[%0d].rdy", tag, i), div_ready_o, rpat[n-1-i]);
            @(negedge clk_i); #1;
            check($sformatf("%s[%0d].lo", tag, i), clk_o, cpat[2*(n-1-i)]);
        end
    endtask

    task automatic skip_cycle();
        @(posedge clk_i);
        @(negedge clk_i); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni         = 1'b0;
        test_mode_en_i = 1'b0;
        en_i           = 1'b1;
        div_i          = 8'd0;
        div_valid_i    = 1'b0;

        // Reset: clock held low, not ready
        run_pat("rst", 3, 64'b000000, 32'b000);
        // Test mode passes clk_i even in reset
        test_mode_en_i = 1'b1;
        run_pat("tm_rst", 2, 64'b1010, 32'b00);
        test_mode_en_i = 1'b0;

        // Release: ready after one cycle, then divide by 4 (2 high / 2 low)
        rst_ni = 1'b1;
        run_pat("div4_go", 1, 64'b00, 32'b1);
        run_pat("div4", 8, 64'b1111000011110000, 32'hFF);

        // en_i drops one cycle into the high phase: period completes, then held low
        run_pat("en_a", 1, 64'b11, 32'b1);
        en_i = 1'b0;
        run_pat("en_off", 7, 64'b11000000000000, 32'h7F);
        en_i = 1'b1;
        run_pat("en_on", 5, 64'b0011110000, 32'h1F);

        // 4 -> 6; a changed request held while not ready must be ignored
        div_i = 8'd6; div_valid_i = 1'b1;
        run_pat("d6_xfer", 1, 64'b11, 32'b0);
        div_i = 8'd5;
        run_pat("d6_hold", 3, 64'b110000, 32'b000);
        div_valid_i = 1'b0;
        run_pat("d6_run", 8, 64'b0011111100000011, 32'hFF);

        // 6 -> 3: odd divisor, high for 1.5 cycles
        div_i = 8'd3; div_valid_i = 1'b1;
        run_pat("d3_xfer", 1, 64'b11, 32'b0);
        div_valid_i = 1'b0;
        run_pat("d3_run", 11, 64'b1100000000111000111000, 32'b00001111111);

        // 3 -> 1: bypass, clk_o follows clk_i
        div_i = 8'd1; div_valid_i = 1'b1;
        run_pat("d1_xfer", 1, 64'b11, 32'b0);
        div_valid_i = 1'b0;
        run_pat("d1_drain", 2, 64'b1000, 32'b00);
        skip_cycle();
        run_pat("d1_byp", 4, 64'b10101010, 32'hF);

        // 1 -> 0: still bypass
        div_i = 8'd0; div_valid_i = 1'b1;
        run_pat("d0_xfer", 1, 64'b10, 32'b0);
        div_valid_i = 1'b0;
        run_pat("d0_run", 5, 64'b1000101010, 32'b01111);

        // 0 -> 2: period 2, no runt pulse at the switch
        div_i = 8'd2; div_valid_i = 1'b1;
        run_pat("d2_xfer", 1, 64'b10, 32'b0);
        div_valid_i = 1'b0;
        run_pat("d2_run", 6, 64'b100011001100, 32'b011111);
        run_pat("d2_more", 1, 64'b11, 32'b1);

        // Reset in the middle of a high phase forces clk_o low at once
        rst_ni = 1'b0;
        #1;
        check("rst_async_clk", clk_o, 1'b0);
        check("rst_async_rdy", div_ready_o, 1'b0);
        test_mode_en_i = 1'b1;
        run_pat("tm_rst2", 2, 64'b1010, 32'b00);
        test_mode_en_i = 1'b0;
        run_pat("rst_hold", 2, 64'b0000, 32'b00);

        // Reset restores DEFAULT_DIV = 4
        rst_ni = 1'b1;
        run_pat("rst_default", 5, 64'b0011110000, 32'h1F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
